// File: rtl/alu_wb_buffer_if.sv
// -----------------------------------------------------------------------------
// alu_wb_buffer_if
// Bundles the ALU-side input, the register-file write port, the forwarding
// lookup ports and the occupancy readout of the ALU writeback buffer.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both 1. The producer must not make valid
// depend on ready. Ex channel: ex_valid_i / ex_ready_o (buffer is consumer).
// Rf channel: rf_we_o / rf_ready_i (buffer is producer); once rf_we_o is
// raised it stays high with stable rf_waddr_o / rf_wdata_o until transferred.
//
// Modports:
//   slave  - the writeback buffer itself
//   master - the environment (ALU, register file, operand-read stage)
// -----------------------------------------------------------------------------
interface alu_wb_buffer_if #(
  parameter int XLEN       = 32,
  parameter int RegAddrW   = 5,
  parameter int Depth      = 2,
  parameter int NumFwdPort = 2
);
  logic                                ex_valid_i;
  logic                                ex_ready_o;
  logic                                ex_we_i;
  logic [RegAddrW-1:0]                 ex_rd_i;
  logic [XLEN-1:0]                     ex_wdata_i;
  logic                                rf_we_o;
  logic                                rf_ready_i;
  logic [RegAddrW-1:0]                 rf_waddr_o;
  logic [XLEN-1:0]                     rf_wdata_o;
  logic [NumFwdPort-1:0][RegAddrW-1:0] fwd_raddr_i;
  logic [NumFwdPort-1:0]               fwd_hit_o;
  logic [NumFwdPort-1:0][XLEN-1:0]     fwd_data_o;
  logic [$clog2(Depth):0]              count_o;

  modport slave (
    input  ex_valid_i, ex_we_i, ex_rd_i, ex_wdata_i, rf_ready_i, fwd_raddr_i,
    output ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, fwd_hit_o, fwd_data_o,
           count_o
  );

  modport master (
    output ex_valid_i, ex_we_i, ex_rd_i, ex_wdata_i, rf_ready_i, fwd_raddr_i,
    input  ex_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, fwd_hit_o, fwd_data_o,
           count_o
  );
endinterface

// File: rtl/alu_wb_buffer.sv
// -----------------------------------------------------------------------------
// alu_wb_buffer
// Writeback stage after the integer ALU. Results that write a non-zero
// register are queued in a small in-order FIFO and drained to the shared
// register-file write port. Buffered results are forwarded youngest-first to
// the operand-read stage while they are pending.
//
// Ports:
//   clk_i  - clock, all state on the rising edge
//   rst_ni - asynchronous active-low reset
//   bus    - alu_wb_buffer_if.slave (ex_*, rf_*, fwd_*, count_o)
// -----------------------------------------------------------------------------
module alu_wb_buffer #(
  parameter int XLEN       = 32,
  parameter int RegAddrW   = 5,
  parameter int Depth      = 2,
  parameter int NumFwdPort = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  alu_wb_buffer_if.slave  bus
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  logic [Depth-1:0]                r_valid;
  logic [Depth-1:0][RegAddrW-1:0]  r_rd;
  logic [Depth-1:0][XLEN-1:0]      r_data;
  logic [PtrW-1:0]                 r_wptr;
  logic [PtrW-1:0]                 r_rptr;
  logic [CntW-1:0]                 r_count;

  logic w_ready;
  logic w_accept;
  logic w_store;
  logic w_head_valid;
  logic w_pop;

  // Ready is a function of registered occupancy only; gating with rst_ni
  // forces it low while reset is asserted.
  assign w_ready      = rst_ni & (r_count < DepthC);
  assign w_accept     = bus.ex_valid_i & w_ready;
  assign w_store      = w_accept & bus.ex_we_i & (bus.ex_rd_i != '0);
  assign w_head_valid = r_valid[r_rptr];
  assign w_pop        = w_head_valid & bus.rf_ready_i;

  assign bus.ex_ready_o = w_ready;
  assign bus.rf_we_o    = w_head_valid;
  assign bus.rf_waddr_o = w_head_valid ? r_rd[r_rptr]   : '0;
  assign bus.rf_wdata_o = w_head_valid ? r_data[r_rptr] : '0;
  assign bus.count_o    = r_count;

  // Store never targets the head slot being popped: a store needs a free slot
  // (not full) and a pop needs a valid head (not empty), so with both active
  // the write pointer is never equal to the read pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_rd    <= '0;
      r_data  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_store) begin
        r_valid[r_wptr] <= 1'b1;
        r_rd[r_wptr]    <= bus.ex_rd_i;
        r_data[r_wptr]  <= bus.ex_wdata_i;
        r_wptr          <= r_wptr + PtrOne;
      end
      if (w_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + PtrOne;
      end
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

  // Forwarding: walk entries oldest to youngest starting at the head, so a
  // later match overrides an earlier one and the youngest value wins.
  always_comb begin : fwd_comb
    logic [PtrW-1:0] idx;
    idx            = '0;
    bus.fwd_hit_o  = '0;
    bus.fwd_data_o = '0;
    for (int p = 0; p < NumFwdPort; p++) begin
      for (int k = 0; k < Depth; k++) begin
        idx = r_rptr + PtrW'(k);
        if (r_valid[idx] && (bus.fwd_raddr_i[p] != '0) &&
            (r_rd[idx] == bus.fwd_raddr_i[p])) begin
          bus.fwd_hit_o[p]  = 1'b1;
          bus.fwd_data_o[p] = r_data[idx];
        end
      end
    end
  end

  a_no_store_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_store |-> (r_count < DepthC));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_pop |-> (r_count != '0));
  a_count_matches: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ($countones(r_valid) == int'(r_count)));
endmodule

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
- Writeback stage directly downstream of the integer ALU.
- Captures each ALU result (operand_wdata_o) with its destination register into a small in-order FIFO, then drains it to the register-file write port under a valid/ready handshake.
- The register-file port is shared with the load unit, so it can stall.
- While entries are pending, provides youngest-first forwarding of buffered results to the operand-read stage.

Parameters:
XLEN, 32, datapath width; matches ALU XLEN.
RegAddrW, 5, register index width.
Depth, 2, FIFO entries; power of two, >= 2.
NumFwdPort, 2, forwarding lookup ports; matches ALU NumInPort.

Ports:
clk_i  input  1  clock, all state on rising edge.
rst_ni  input  1  reset, asynchronous assert, active-low.
ex_valid_i  input  1  ALU result valid this cycle.
ex_ready_o  output  1  buffer can accept a result.
ex_we_i  input  1  instruction writes a register.
ex_rd_i  input  RegAddrW  destination register.
ex_wdata_i  input  XLEN  ALU result.
rf_we_o  output  1  write request to register file.
rf_ready_i  input  1  register file accepts the write this cycle.
rf_waddr_o  output  RegAddrW  write address.
rf_wdata_o  output  XLEN  write data.
fwd_raddr_i  input  NumFwdPort x RegAddrW  source registers being read.
fwd_hit_o  output  NumFwdPort  a pending entry matches the lookup.
fwd_data_o  output  NumFwdPort x XLEN  forwarded data.
count_o  output  $clog2(Depth)+1  current occupancy.

Behaviour:
- Reset, asynchronous while rst_ni=0:
  - write/read pointers = 0, count_o = 0, all entry valid bits = 0.
  - rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, fwd_hit_o = 0, fwd_data_o = 0, ex_ready_o = 0.
  - Reset mid-operation discards all pending entries; no write is issued.
- ex_ready_o = 1 iff out of reset and count_o < Depth.
  - Registered-state-only; no combinational path from rf_ready_i.
  - When full, a same-cycle pop does not open the input.
- Accept = ex_valid_i & ex_ready_o.
  - An accepted result is stored only if ex_we_i=1 and ex_rd_i != 0.
  - Otherwise it is accepted and dropped: no entry, no write, count unchanged.
- Storing writes the entry at the write pointer; the pointer increments modulo Depth (wraps at Depth-1 -> 0).
- Head output:
  - rf_we_o = head entry valid.
  - rf_waddr_o / rf_wdata_o = head contents when valid, else 0.
- Pop = rf_we_o & rf_ready_i: clears the head and increments the read pointer modulo Depth.
- Latency: a result accepted in cycle N presents rf_we_o=1 in cycle N+1 at the earliest, or later if older entries are pending.
- Ordering: strictly in-order. rf_we_o must stay asserted with stable addr/data until popped.
- Simultaneous store and pop: count_o unchanged; both pointers advance.
- Forwarding, per port p (combinational from stored entries only, not from ex_* inputs):
  - fwd_hit_o[p] = any valid entry with rd == fwd_raddr_i[p].
  - fwd_data_o[p] = data of the youngest matching entry, else 0.
  - fwd_raddr_i[p]=0 never hits.
  - An entry being popped in the current cycle still forwards in that cycle.
- Invariant: count_o = number of valid entries, always 0..Depth. Never store when full; never pop when empty (assertions).

Test Plan:
- Reset then single accept: ex_valid_i=1, we=1, rd=5, data=0x0000_00AA, rf_ready_i=1 -> next cycle rf_we_o=1, waddr=5, wdata=0xAA; following cycle rf_we_o=0, count_o=0.
- Backpressure/full: rf_ready_i=0, push rd=1 data=0x11 then rd=2 data=0x22 -> count_o=2, ex_ready_o=0. A third valid is held off. Raise rf_ready_i -> writes 0x11 then 0x22 in order, ex_ready_o returns 1 the cycle after the first pop.
- Drop rules: push rd=0 we=1, then rd=7 we=0 -> both accepted, count_o stays 0, rf_we_o never asserts.
- Forwarding priority: rf_ready_i=0, push rd=3 data=0x100 then rd=3 data=0x200; fwd_raddr_i[0]=3, fwd_raddr_i[1]=4 -> fwd_hit_o=2'b01, fwd_data_o[0]=0x200. fwd_raddr=0 -> no hit.
- Wrap-around with concurrent push/pop: rf_ready_i=1, stream 10 back-to-back results rd=1..10 data=i*0x10 -> 10 writes in order, one per cycle after first, count_o never exceeds 1, pointers wrap without loss.
- Reset mid-operation: two entries pending, rf_ready_i=0, drop rst_ni asynchronously between edges -> rf_we_o, count_o, fwd_hit_o go 0 immediately; after release no stale write appears.
